score_timer: RTL and testbench

//  Score keeper and per-level countdown timer, directly downstream of the game FSM.

---
 rtl/pokemaze_pkg.sv | 27 ++
 rtl/score_timer_sync_edge.sv | 22 ++
 rtl/score_timer.sv | 219 +++++++++++++++++++++
 tb/tb_score_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pokemaze_pkg.sv
// Shared types for the game datapath.
// BCD digit helpers and score/timer FSM states.
package pokemaze_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BONUS,
    EXPIRED
  } st_score_e;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_inc(
    input  bcd_t d,
    output logic carry
  );
    if (d >= 4'd9) begin
      carry   = 1'b1;
      bcd_inc = 4'd0;
    end else begin
      carry   = 1'b0;
      bcd_inc = d + 4'd1;
    end
  endfunction

endpackage

// File: rtl/score_timer_sync_edge.sv
// Two-flop synchroniser with a one-cycle
// rising-edge pulse on the synchronised level.
module sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic [2:0] sh;

  // shift chain: two sync stages plus one history flop
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sh <= '0;
    else       sh <= {sh[1:0], d};
  end

  assign lvl  = sh[1];
  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/score_timer.sv
// Score keeper and per-level countdown timer
// feeding the HUD and the game FSM timeout flag.
module score_timer
  import pokemaze_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_INIT      = 90,
  parameter int PTS_PER_CATCH  = 1,
  parameter int MAX_LEVEL      = 9
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        clr,
  input  logic        inc,
  input  logic        score_CU,
  input  logic        game_run,
  output logic [15:0] score_bcd,
  output logic [3:0]  level,
  output logic [7:0]  time_left,
  output logic        time_up,
  output logic        busy
);

  localparam int FW = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [FW-1:0] F_LAST =
    FW'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] TL_INIT =
    {4'(TIME_INIT / 10), 4'(TIME_INIT % 10)};
  localparam bcd_t PTS     = 4'(PTS_PER_CATCH);
  localparam logic [3:0] LVL_MAX = 4'(MAX_LEVEL);

  // Four-digit BCD add of one digit, saturating at 9999.
  function automatic logic [15:0] score_add(
    input logic [15:0] s,
    input bcd_t        k
  );
    logic [4:0] sum;
    logic [4:0] sum_m;
    logic       c;
    bcd_t       d0, d1, d2, d3;
    sum   = {1'b0, s[3:0]} + {1'b0, k};
    sum_m = sum - 5'd10;
    if (sum > 5'd9) begin
      d0 = sum_m[3:0];
      c  = 1'b1;
    end else begin
      d0 = sum[3:0];
      c  = 1'b0;
    end
    d1 = s[7:4];
    if (c) d1 = bcd_inc(s[7:4], c);
    d2 = s[11:8];
    if (c) d2 = bcd_inc(s[11:8], c);
    d3 = s[15:12];
    if (c) d3 = bcd_inc(s[15:12], c);
    if (c) score_add = 16'h9999;
    else   score_add = {d3, d2, d1, d0};
  endfunction

  // Two-digit BCD decrement; callers never pass 00.
  function automatic logic [7:0] tl_dec(
    input logic [7:0] t
  );
    if (t[3:0] == 4'd0)
      tl_dec = {t[7:4] - 4'd1, 4'd9};
    else
      tl_dec = {t[7:4], t[3:0] - 4'd1};
  endfunction

  logic frame_tick, catch_p, clr_s;
  logic frame_lvl_unused, catch_lvl_unused;
  logic clr_rise_unused;
  logic inc_q, lvl_p;

  sync_edge u_frame (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (frame_clk),
    .lvl   (frame_lvl_unused),
    .rise  (frame_tick)
  );

  sync_edge u_catch (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (score_CU),
    .lvl   (catch_lvl_unused),
    .rise  (catch_p)
  );

  sync_edge u_clr (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (clr),
    .lvl   (clr_s),
    .rise  (clr_rise_unused)
  );

  // inc is already in the Clk domain; edge only
  assign lvl_p = inc & ~inc_q;

  st_score_e       state_q, state_n;
  logic [15:0]     score_n, bonus_sc;
  logic [3:0]      level_n;
  logic [7:0]      tl_n;
  logic [FW-1:0]   frame_q, frame_n;
  logic            time_up_n, busy_n;
  logic            pend_q, pend_n;

  // state and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      score_bcd <= '0;
      level     <= 4'd1;
      time_left <= TL_INIT;
      frame_q   <= '0;
      time_up   <= 1'b0;
      busy      <= 1'b0;
      pend_q    <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      score_bcd <= score_n;
      level     <= level_n;
      time_left <= tl_n;
      frame_q   <= frame_n;
      time_up   <= time_up_n;
      busy      <= busy_n;
      pend_q    <= pend_n;
      inc_q     <= inc;
    end
  end

  // next-state, score, timer and level update
  always_comb begin
    state_n   = state_q;
    score_n   = score_bcd;
    level_n   = level;
    tl_n      = time_left;
    frame_n   = frame_q;
    time_up_n = time_up;
    busy_n    = busy;
    pend_n    = pend_q;
    bonus_sc  = score_bcd;
    if (clr_s) begin
      state_n   = IDLE;
      score_n   = '0;
      level_n   = 4'd1;
      tl_n      = TL_INIT;
      frame_n   = '0;
      time_up_n = 1'b0;
      busy_n    = 1'b0;
      pend_n    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (catch_p)
            score_n = score_add(score_bcd, PTS);
          if (game_run) state_n = RUN;
        end
        RUN: begin
          if (catch_p)
            score_n = score_add(score_bcd, PTS);
          if (lvl_p) begin
            state_n = BONUS;
            busy_n  = 1'b1;
          end else if (!game_run) begin
            state_n = IDLE;
          end else if (frame_tick) begin
            if (frame_q == F_LAST) begin
              frame_n = '0;
              tl_n    = tl_dec(time_left);
              if (time_left == 8'h01) begin
                time_up_n = 1'b1;
                state_n   = EXPIRED;
              end
            end else begin
              frame_n = frame_q + 1'b1;
            end
          end
        end
        BONUS: begin
          busy_n = 1'b1;
          if (catch_p) pend_n = 1'b1;
          if (time_left > 8'h01) begin
            tl_n    = tl_dec(time_left);
            score_n = score_add(score_bcd, 4'd1);
          end else begin
            // last second and reload share a cycle
            if (time_left == 8'h01)
              bonus_sc = score_add(score_bcd, 4'd1);
            if (pend_q || catch_p)
              bonus_sc = score_add(bonus_sc, PTS);
            score_n = bonus_sc;
            pend_n  = 1'b0;
            tl_n    = TL_INIT;
            frame_n = '0;
            if (level < LVL_MAX)
              level_n = level + 4'd1;
            busy_n  = 1'b0;
            state_n = RUN;
          end
        end
        EXPIRED: begin
          time_up_n = 1'b1;
          if (lvl_p) begin
            state_n   = BONUS;
            busy_n    = 1'b1;
            time_up_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_timer.sv
// Directed bench for score_timer: vector table
// plus hand sequences for timeout and reset cases.
module tb_score_timer;

  logic        Clk, Reset;
  logic        frame_clk, clr, inc;
  logic        score_CU, game_run;
  logic [15:0] score_bcd;
  logic [3:0]  level;
  logic [7:0]  time_left;
  logic        time_up, busy;

  int checks = 0;
  int errors = 0;

  score_timer #(
    .FRAMES_PER_SEC (2),
    .TIME_INIT      (90),
    .PTS_PER_CATCH  (1),
    .MAX_LEVEL      (9)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .clr       (clr),
    .inc       (inc),
    .score_CU  (score_CU),
    .game_run  (game_run),
    .score_bcd (score_bcd),
    .level     (level),
    .time_left (time_left),
    .time_up   (time_up),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam int OP_CATCH = 0;
  localparam int OP_FRAME = 1;
  localparam int OP_BONUS = 2;

  typedef struct {
    int          op;
    int          n;
    logic [15:0] sc;
    logic [3:0]  lv;
    logic [7:0]  tl;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_edge();
    frame_clk = 1'b1;
    repeat (3) cyc();
    frame_clk = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic catch_pulse();
    score_CU = 1'b1;
    repeat (3) cyc();
    score_CU = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic bonus_run();
    int n;
    inc = 1'b1;
    cyc();
    inc = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      cyc();
      n++;
    end
    chk("bonus_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    repeat (4) cyc();
    clr = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic apply_row(input int i);
    for (int k = 0; k < tbl[i].n; k++) begin
      case (tbl[i].op)
        OP_CATCH: catch_pulse();
        OP_FRAME: frame_edge();
        default:  bonus_run();
      endcase
    end
    chk($sformatf("row%0d_score", i),
        {16'd0, score_bcd}, {16'd0, tbl[i].sc});
    chk($sformatf("row%0d_level", i),
        {28'd0, level}, {28'd0, tbl[i].lv});
    chk($sformatf("row%0d_time", i),
        {24'd0, time_left}, {24'd0, tbl[i].tl});
  endtask

  initial begin
    int bcnt, n, early, tu_seen;

    tbl[0] = '{OP_CATCH, 10,  16'h0010, 4'd1, 8'h90};
    tbl[1] = '{OP_FRAME, 130, 16'h0010, 4'd1, 8'h25};
    tbl[2] = '{OP_BONUS, 109, 16'h9845, 4'd9, 8'h90};
    tbl[3] = '{OP_BONUS, 1,   16'h9935, 4'd9, 8'h90};
    tbl[4] = '{OP_BONUS, 1,   16'h9999, 4'd9, 8'h90};
    tbl[5] = '{OP_CATCH, 1,   16'h9999, 4'd9, 8'h90};
    tbl[6] = '{OP_FRAME, 2,   16'h9999, 4'd9, 8'h89};

    Reset     = 1'b1;
    frame_clk = 1'b0;
    clr       = 1'b0;
    inc       = 1'b0;
    score_CU  = 1'b0;
    game_run  = 1'b0;
    repeat (3) cyc();
    Reset = 1'b0;
    cyc();
    chk("rst_score", {16'd0, score_bcd}, 32'h0);
    chk("rst_level", {28'd0, level}, 32'd1);
    chk("rst_time", {24'd0, time_left}, 32'h90);
    chk("rst_time_up", {31'd0, time_up}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // two timer seconds at two frames per second
    game_run = 1'b1;
    cyc();
    repeat (4) frame_edge();
    chk("t1_time", {24'd0, time_left}, 32'h88);
    chk("t1_time_up", {31'd0, time_up}, 32'd0);

    // count down to expiry
    repeat (175) frame_edge();
    chk("t2_time01", {24'd0, time_left}, 32'h01);
    chk("t2_tu_before", {31'd0, time_up}, 32'd0);
    frame_clk = 1'b1;
    n = 0;
    early = 0;
    cyc();
    while (time_left != 8'h00 && n < 10) begin
      if (time_up) early = 1;
      cyc();
      n++;
    end
    chk("t2_tu_early", early, 0);
    chk("t2_time00", {24'd0, time_left}, 32'h00);
    chk("t2_tu_on_tick", {31'd0, time_up}, 32'd1);
    frame_clk = 1'b0;
    repeat (3) cyc();
    repeat (2) frame_edge();
    catch_pulse();
    chk("t2_tu_held", {31'd0, time_up}, 32'd1);
    chk("t2_time_held", {24'd0, time_left}, 32'h00);
    chk("t2_catch_ign", {16'd0, score_bcd}, 32'h0);
    do_clr();
    chk("t2_clr_tu", {31'd0, time_up}, 32'd0);
    chk("t2_clr_time", {24'd0, time_left}, 32'h90);
    chk("t2_clr_level", {28'd0, level}, 32'd1);
    chk("t2_clr_score", {16'd0, score_bcd}, 32'h0);

    for (int i = 0; i < 2; i++) apply_row(i);

    // inc held five cycles at 25 seconds left
    bcnt = 0;
    inc = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (k == 4) inc = 1'b0;
      if (busy) bcnt++;
    end
    chk("t4_busy_cycles", bcnt, 25);
    chk("t4_score", {16'd0, score_bcd}, 32'h0035);
    chk("t4_level", {28'd0, level}, 32'd2);
    chk("t4_time", {24'd0, time_left}, 32'h90);

    for (int i = 2; i < 7; i++) apply_row(i);

    // level advance coinciding with the final tick
    do_clr();
    repeat (179) frame_edge();
    chk("t5_time01", {24'd0, time_left}, 32'h01);
    frame_clk = 1'b1;
    cyc();
    cyc();
    inc = 1'b1;
    cyc();
    chk("t5_busy", {31'd0, busy}, 32'd1);
    tu_seen = time_up ? 1 : 0;
    inc = 1'b0;
    frame_clk = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (time_up) tu_seen = 1;
    end
    chk("t5_tu_never", tu_seen, 0);
    chk("t5_level", {28'd0, level}, 32'd2);
    chk("t5_time", {24'd0, time_left}, 32'h90);

    // asynchronous reset during a bonus with a pended catch
    inc = 1'b1;
    cyc();
    inc = 1'b0;
    catch_pulse();
    chk("t6_in_bonus", {31'd0, busy}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_score", {16'd0, score_bcd}, 32'h0);
    chk("t6_level", {28'd0, level}, 32'd1);
    chk("t6_time", {24'd0, time_left}, 32'h90);
    chk("t6_time_up", {31'd0, time_up}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    repeat (2) cyc();
    Reset = 1'b0;
    repeat (10) cyc();
    chk("t6_no_pend", {16'd0, score_bcd}, 32'h0);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
